// File: rtl/bip_pkg.sv
// Shared definitions for the BIP sequencer: FSM state encoding and opcode map.
`timescale 1ns/1ps
package bip_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_MEMWAIT = 3'd3,
      ST_EXEC    = 3'd4,
      ST_PAUSE   = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   localparam logic [4:0] OP_HALT = 5'b00000;
   localparam logic [4:0] OP_LD   = 5'b00001;
   localparam logic [4:0] OP_LDI  = 5'b00010;
   localparam logic [4:0] OP_STO  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_SUB  = 5'b00110;
   localparam logic [4:0] OP_SUBI = 5'b00111;
   localparam logic [4:0] OP_LAST = 5'b00111;

endpackage

// File: rtl/bip_sequencer.sv
// Instruction sequencer for the BIP core: fetch/decode/exec control with
// optional RAM read wait states, single-step pause and a saturating cycle counter.
`timescale 1ns/1ps
module bip_sequencer
   import bip_pkg::*;
#(
   parameter int MEM_WAIT  = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic                 STEP_MODE,
   input  logic                 STEP,
   input  logic [4:0]           OPCODE,
   input  logic                 DEC_WR_PC,
   input  logic                 DEC_WR_ACC,
   input  logic                 DEC_WR_RAM,
   input  logic                 DEC_RD_RAM,
   output logic                 PC_CLR,
   output logic                 IR_LOAD,
   output logic                 WR_PC_EN,
   output logic                 WR_ACC_EN,
   output logic                 WR_RAM_EN,
   output logic                 RD_RAM_EN,
   output logic                 BUSY,
   output logic                 HALTED,
   output logic                 ILLEGAL,
   output logic [CNT_WIDTH-1:0] CYCLE_CNT
);

   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);
   localparam logic       HAS_WAIT  = (MEM_WAIT > 0);

   state_t     state;
   logic [2:0] wait_cnt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   function automatic logic counted(input state_t s);
      return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_MEMWAIT) || (s == ST_EXEC);
   endfunction

   // Every output is set for the state being entered, so outputs track the state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         PC_CLR    <= 1'b0;
         IR_LOAD   <= 1'b0;
         WR_PC_EN  <= 1'b0;
         WR_ACC_EN <= 1'b0;
         WR_RAM_EN <= 1'b0;
         RD_RAM_EN <= 1'b0;
         BUSY      <= 1'b0;
         HALTED    <= 1'b0;
         ILLEGAL   <= 1'b0;
         CYCLE_CNT <= '0;
      end else begin
         PC_CLR    <= 1'b0;
         IR_LOAD   <= 1'b0;
         WR_PC_EN  <= 1'b0;
         WR_ACC_EN <= 1'b0;
         WR_RAM_EN <= 1'b0;
         RD_RAM_EN <= 1'b0;
         if (counted(state))
            CYCLE_CNT <= sat_inc(CYCLE_CNT);

         case (state)
            ST_IDLE, ST_HALT: begin
               if (START) begin
                  state     <= ST_FETCH;
                  PC_CLR    <= 1'b1;
                  IR_LOAD   <= 1'b1;
                  BUSY      <= 1'b1;
                  HALTED    <= 1'b0;
                  ILLEGAL   <= 1'b0;
                  CYCLE_CNT <= '0;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               if (OPCODE == OP_HALT) begin
                  state  <= ST_HALT;
                  BUSY   <= 1'b0;
                  HALTED <= 1'b1;
               end else if (OPCODE > OP_LAST) begin
                  state   <= ST_HALT;
                  BUSY    <= 1'b0;
                  HALTED  <= 1'b1;
                  ILLEGAL <= 1'b1;
               end else if (DEC_RD_RAM && HAS_WAIT) begin
                  state     <= ST_MEMWAIT;
                  wait_cnt  <= WAIT_INIT;
                  RD_RAM_EN <= 1'b1;
               end else begin
                  state     <= ST_EXEC;
                  WR_PC_EN  <= DEC_WR_PC;
                  WR_ACC_EN <= DEC_WR_ACC;
                  WR_RAM_EN <= DEC_WR_RAM;
                  RD_RAM_EN <= DEC_RD_RAM;
               end
            end
            ST_MEMWAIT: begin
               wait_cnt <= wait_cnt - 3'd1;
               if (wait_cnt == 3'd1) begin
                  state     <= ST_EXEC;
                  WR_PC_EN  <= DEC_WR_PC;
                  WR_ACC_EN <= DEC_WR_ACC;
                  WR_RAM_EN <= DEC_WR_RAM;
                  RD_RAM_EN <= DEC_RD_RAM;
               end else begin
                  RD_RAM_EN <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (STEP_MODE) begin
                  state <= ST_PAUSE;
                  BUSY  <= 1'b0;
               end else begin
                  state   <= ST_FETCH;
                  IR_LOAD <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (STEP || !STEP_MODE) begin
                  state   <= ST_FETCH;
                  IR_LOAD <= 1'b1;
                  BUSY    <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Abort overrides whatever the case statement scheduled above.
         if (ABORT) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            PC_CLR    <= 1'b0;
            IR_LOAD   <= 1'b0;
            WR_PC_EN  <= 1'b0;
            WR_ACC_EN <= 1'b0;
            WR_RAM_EN <= 1'b0;
            RD_RAM_EN <= 1'b0;
            BUSY      <= 1'b0;
            HALTED    <= 1'b0;
            ILLEGAL   <= 1'b0;
            CYCLE_CNT <= '0;
         end
      end
   end

endmodule

// File: doc/bip_sequencer.md
BIP_SEQUENCER -- requirements
Module: bip_sequencer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  MEM_WAIT, 1, extra cycles RAM read data needs before EXEC (0..7).
  CNT_WIDTH, 16, width of CYCLE_CNT.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  CLK  in  1  single clock, rising edge.
  RST_N  in  1  reset; asynchronous, active-low.
  START  in  1  one-cycle pulse: start program from PC 0.
  ABORT  in  1  one-cycle pulse: return to IDLE.
  STEP_MODE  in  1  1 = pause after every instruction.
  STEP  in  1  one-cycle pulse: release one instruction while paused.
  OPCODE  in  5  opcode field of instruction register.
  DEC_WR_PC, DEC_WR_ACC, DEC_WR_RAM, DEC_RD_RAM  in  1 each  raw opcode-decoder strobes.
  PC_CLR  out  1  clear program counter.
  IR_LOAD  out  1  capture instruction memory output into IR.
  WR_PC_EN, WR_ACC_EN, WR_RAM_EN, RD_RAM_EN  out  1 each  gated strobes to datapath.
  BUSY  out  1  state is not IDLE, HALT or PAUSE.
  HALTED  out  1  state is HALT.
  ILLEGAL  out  1  sticky: halted on an undefined opcode.
  CYCLE_CNT  out  CNT_WIDTH  cycles spent executing the current run.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, DECODE, MEMWAIT, EXEC, PAUSE and HALT.
REQ-004 In IDLE or HALT, START SHALL pulse PC_CLR for 1 cycle, clear CYCLE_CNT and ILLEGAL, and go to FETCH.
REQ-005 FETCH SHALL assert IR_LOAD for exactly 1 cycle and then go to DECODE.
REQ-006 In DECODE, OPCODE 5'b00000 (HALT) SHALL go to HALT with ILLEGAL=0.
REQ-007 In DECODE, OPCODE above 5'b00111 SHALL go to HALT with ILLEGAL=1.
REQ-008 In DECODE, any other opcode with DEC_RD_RAM=1 and MEM_WAIT>0 SHALL load a wait counter with MEM_WAIT and go to MEMWAIT; otherwise it SHALL go to EXEC.
REQ-009 MEMWAIT SHALL hold RD_RAM_EN=1, decrement the counter each cycle, and go to EXEC in the cycle after it reaches 1.
REQ-010 EXEC SHALL last 1 cycle and drive WR_PC_EN, WR_ACC_EN, WR_RAM_EN and RD_RAM_EN equal to the DEC_* inputs; all four SHALL be 0 in every other state except RD_RAM_EN in MEMWAIT.
REQ-011 After EXEC the FSM SHALL go to PAUSE if STEP_MODE=1, else to FETCH.
REQ-012 PAUSE SHALL go to FETCH on STEP; it SHALL go to FETCH without STEP if STEP_MODE falls to 0.
REQ-013 Latency SHALL be 3 cycles per instruction (FETCH, DECODE, EXEC), or 3+MEM_WAIT for RAM reads.
REQ-014 CYCLE_CNT SHALL increment in FETCH, DECODE, MEMWAIT and EXEC only, and SHALL saturate at all-ones with no wrap.
REQ-015 ABORT SHALL force IDLE from any state on the next edge and has priority over START and STEP.
REQ-016 START outside IDLE/HALT, and STEP outside PAUSE, SHALL be ignored.
REQ-017 Reaching HALT SHALL leave CYCLE_CNT frozen; HALTED and ILLEGAL SHALL hold until START, ABORT or reset.
REQ-018 All outputs SHALL be registered or decoded from the state register only (no combinational path from START, STEP or ABORT to outputs).

Reset
REQ-019 RST_N=0 SHALL asynchronously force state to IDLE, the wait counter and CYCLE_CNT to 0, and every output to 0.
REQ-020 Reset asserted mid-instruction SHALL suppress every pending strobe in the same cycle.
REQ-021 Leaving reset SHALL not start execution; a START pulse is required.

Structure
REQ-022 A shared package bip_pkg SHALL hold the state encoding, opcode constants OP_HALT..OP_SUBI (5'b00000..5'b00111) and OP_LAST=5'b00111.
REQ-023 The opcode decoder SHALL stay outside this block; no sub-module is required, and the wait counter SHALL be inline.

Verification
REQ-024 The bench SHALL cover these scenarios:
  Program LDI, ADDI, HALT with MEM_WAIT=1 and START -> PC_CLR 1 cycle; WR_ACC_EN high in cycles 3 and 6 after FETCH entry; HALTED=1; CYCLE_CNT=8 (3+3+2).
  LD with MEM_WAIT=3 -> RD_RAM_EN high 4 consecutive cycles (3 MEMWAIT + EXEC); WR_ACC_EN only in EXEC.
  STEP_MODE=1, three STO instructions -> PAUSE after each; exactly one WR_RAM_EN per STEP pulse; STEP in FETCH ignored.
  OPCODE 5'b01010 -> HALTED=1, ILLEGAL=1, no DEC_* strobe reaches its *_EN output.
  ABORT and START in the same cycle during EXEC -> IDLE, all outputs 0, no PC_CLR.
  RST_N low for 1 cycle during MEMWAIT -> RD_RAM_EN drops immediately; state IDLE with CYCLE_CNT=0; CNT_WIDTH=4 run of 6 instructions -> CYCLE_CNT saturates at 15.
